// File: rtl/ccff_bitstream_loader_pkg.sv
// ccff_cfg_pkg: values shared by the configuration-chain loader.
//   ccff_state_e : loader FSM state encoding (IDLE, RUN, FIN)
//   DEF_WORD_W   : default bitstream / readback word width
//   DEF_LEN_W    : default width of the chain length (max chain 2**LEN_W-1 bits)
package ccff_cfg_pkg;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_LEN_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } ccff_state_e;
endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word stream into the loader (valid/ready, bit 0 shifted first).
//   s_valid : word valid (producer)
//   s_ready : loader can take a word (loader)
//   s_data  : bitstream word (producer)
// master = word producer, slave = loader.
interface ccff_bitstream_loader_if
  import ccff_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ccff_rb_packer.sv
// Serial-to-word packer for chain readback.
//   clk, rst_n : clock, async active-low reset
//   sample_en  : sample_bit is valid this cycle
//   sample_bit : serial bit, first sample lands in bit 0
//   flush      : emit whatever is pending (including this cycle's sample), zero-padded
//   rb_valid   : 1-cycle pulse, rb_data holds a packed word
//   rb_data    : packed word, held between pulses
module ccff_rb_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic              sample_bit,
  input  logic              flush,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] acc_q, acc_d, acc_n;
  logic [CNT_W-1:0]  n_q, n_d, n_n;
  logic              rb_valid_q, rb_valid_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              emit;

  always_comb begin
    acc_n = acc_q;
    n_n   = n_q;
    if (sample_en) begin
      acc_n[n_q[IDX_W-1:0]] = sample_bit;
      n_n = n_q + CNT_W'(1);
    end
    // Full word, or a flush with anything pending. The accumulator is cleared on
    // every emit, which is what zero-pads a partial word.
    emit       = (n_n == CNT_W'(WORD_W)) || (flush && (n_n != '0));
    rb_valid_d = emit;
    rb_data_d  = emit ? acc_n : rb_data_q;
    acc_d      = emit ? '0 : acc_n;
    n_d        = emit ? '0 : n_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      n_q        <= '0;
      rb_valid_q <= 1'b0;
      rb_data_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      n_q        <= n_d;
      rb_valid_q <= rb_valid_d;
      rb_data_q  <= rb_data_d;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises bitstream words LSB-first onto the chain
// head with a per-cycle shift enable, and packs chain-tail bits back into words.
//   prog_clk, pReset : clock, async active-low reset
//   start, chain_len : load request (IDLE only) and number of bits to shift
//   s                : bitstream word stream (slave side)
//   ccff_head        : serial data to chain head (registered)
//   ccff_shift_en    : chain shifts at the next prog_clk edge (registered)
//   ccff_tail        : serial data from chain tail
//   rb_valid/rb_data : packed readback word pulse
//   busy, done       : busy from accepted start through FIN; done pulses in FIN
module ccff_bitstream_loader
  import ccff_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                    prog_clk,
  input  logic                    pReset,
  input  logic                    start,
  input  logic [LEN_W-1:0]        chain_len,
  ccff_bitstream_loader_if.slave  s,
  output logic                    ccff_head,
  output logic                    ccff_shift_en,
  input  logic                    ccff_tail,
  output logic                    rb_valid,
  output logic [WORD_W-1:0]       rb_data,
  output logic                    busy,
  output logic                    done
);
  localparam int CNT_W = $clog2(WORD_W + 1);

  ccff_state_e       state_q, state_d;
  logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;    // bits still to be shifted
  logic [LEN_W-1:0]  acc_left_q, acc_left_d;  // bits not yet covered by accepted words
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  sr_cnt_q, sr_cnt_d;      // valid bits left in SR
  logic [WORD_W-1:0] hb_q, hb_d;
  logic [CNT_W-1:0]  hb_bits_q, hb_bits_d;    // valid bits in HB (short for the last word)
  logic              hb_full_q, hb_full_d;
  logic              head_q, head_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept, shift, flush;
  logic [CNT_W-1:0]  take;

  assign s.s_ready = (state_q == ST_RUN) && !hb_full_q && (acc_left_q != '0);
  assign accept    = s.s_valid && s.s_ready;
  assign shift     = (state_q == ST_RUN) && (sr_cnt_q != '0);
  // bit_cnt reaches 0 one cycle ahead of the last shift_en cycle, so in RUN with
  // bit_cnt==0 the final tail bit is being sampled: flush readback now so the
  // padded word and done land in the same FIN cycle.
  assign flush     = (state_q == ST_RUN) && (bit_cnt_q == '0);

  always_comb begin
    take = (acc_left_q >= LEN_W'(WORD_W)) ? CNT_W'(WORD_W) : CNT_W'(acc_left_q);
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    acc_left_d = acc_left_q;
    sr_d       = sr_q;
    sr_cnt_d   = sr_cnt_q;
    hb_d       = hb_q;
    hb_bits_d  = hb_bits_q;
    hb_full_d  = hb_full_q;
    head_d     = head_q;      // head holds through stalls
    shift_en_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bit_cnt_d  = chain_len;
          acc_left_d = chain_len;
          sr_cnt_d   = '0;
          hb_full_d  = 1'b0;
          state_d    = (chain_len == '0) ? ST_FIN : ST_RUN;
          done_d     = (chain_len == '0);
        end
      end
      ST_RUN: begin
        if (shift) begin
          head_d     = sr_q[0];
          shift_en_d = 1'b1;
          sr_d       = sr_q >> 1;
          sr_cnt_d   = sr_cnt_q - CNT_W'(1);
          if (bit_cnt_q != '0) bit_cnt_d = bit_cnt_q - LEN_W'(1);
        end
        // Refill on the same edge SR runs dry so a steady stream never bubbles.
        if ((sr_cnt_d == '0) && hb_full_q) begin
          sr_d      = hb_q;
          sr_cnt_d  = hb_bits_q;
          hb_full_d = 1'b0;
        end
        if (accept) begin
          hb_d       = s.s_data;
          hb_bits_d  = take;
          hb_full_d  = 1'b1;
          acc_left_d = acc_left_q - LEN_W'(take);
        end
        if (flush) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      acc_left_q <= '0;
      sr_q       <= '0;
      sr_cnt_q   <= '0;
      hb_q       <= '0;
      hb_bits_q  <= '0;
      hb_full_q  <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_left_q <= acc_left_d;
      sr_q       <= sr_d;
      sr_cnt_q   <= sr_cnt_d;
      hb_q       <= hb_d;
      hb_bits_q  <= hb_bits_d;
      hb_full_q  <= hb_full_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

  ccff_rb_packer #(.WORD_W(WORD_W)) u_rb_packer (
    .clk        (prog_clk),
    .rst_n      (pReset),
    .sample_en  (shift_en_q),
    .sample_bit (ccff_tail),
    .flush      (flush),
    .rb_valid   (rb_valid),
    .rb_data    (rb_data)
  );
endmodule
